uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_if.sv | 20 ++
 rtl/uart_transmitter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// Host-side bus of the UART transmitter: write strobe, data, rate and status.
interface uart_transmitter_if;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  modport master (
    output baud_select, Tx_EN, Tx_WR, Tx_DATA,
    input  TxD, Tx_BUSY, Tx_DONE
  );

  modport slave (
    input  baud_select, Tx_EN, Tx_WR, Tx_DATA,
    output TxD, Tx_BUSY, Tx_DONE
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter, start/8 data/stop; even parity bit added when
// UART_TX_PARITY_EN is defined. Rate and byte are latched on accept.
module uart_transmitter #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_transmitter_if.slave  bus
);

  localparam int CW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_data;
  logic        r_par;
  logic [2:0]  r_baud;
  logic [13:0] r_div;
  logic [CW-1:0] r_cnt;
  logic        r_txd;
  logic        r_done;
  logic        w_txd_nxt;
  logic        w_done;
  logic        w_accept;
  logic        w_tick;
  logic        w_bit_end;

  // Divider terminal count (N-1) per rate code
  function automatic logic [13:0] div_max(input logic [2:0] code);
    unique case (code)
      3'd0: div_max = 14'd10416;
      3'd1: div_max = 14'd2603;
      3'd2: div_max = 14'd650;
      3'd3: div_max = 14'd325;
      3'd4: div_max = 14'd162;
      3'd5: div_max = 14'd80;
      3'd6: div_max = 14'd53;
      3'd7: div_max = 14'd26;
    endcase
  endfunction

  assign w_accept  = (r_state == IDLE) && bus.Tx_WR && bus.Tx_EN;
  assign w_tick    = (r_div == div_max(r_baud));
  assign w_bit_end = w_tick &&
                     (r_cnt == CW'(SAMPLES_PER_BIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_bit_nxt   = 3'd0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Losing enable abandons the frame silently
    if (r_state != IDLE && !bus.Tx_EN) begin
      w_state_nxt = IDLE;
      w_bit_nxt   = 3'd0;
      w_done      = 1'b0;
    end
  end

  always_comb begin
    w_txd_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = r_data[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txd_nxt = r_par;
`endif
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_bit   <= 3'd0;
      r_data  <= 8'h00;
      r_par   <= 1'b0;
      r_baud  <= 3'd0;
      r_div   <= 14'd0;
      r_cnt   <= '0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_txd   <= w_txd_nxt;
      r_done  <= w_done;
      if (w_accept) begin
        r_data <= bus.Tx_DATA;
        r_par  <= ^bus.Tx_DATA;
        r_baud <= bus.baud_select;
      end
      // Timebase restarts on accept so every bit is a full period
      if (w_accept || r_state == IDLE) begin
        r_div <= 14'd0;
        r_cnt <= '0;
      end else if (w_tick) begin
        r_div <= 14'd0;
        r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
      end else begin
        r_div <= r_div + 14'd1;
      end
    end
  end

  assign bus.TxD     = r_txd;
  assign bus.Tx_BUSY = (r_state != IDLE);
  assign bus.Tx_DONE = r_done;

endmodule
